// File: rtl/roberto_sonar.sv
// Three-channel HC-SR04 ranging controller with ASCII distance report over UART.
// Define ROBERTO_CRLF_EN to append CR/LF to each report.
module roberto_sonar #(
  parameter int CLK_HZ      = 50_000_000,
  parameter int BAUD_DIV    = CLK_HZ / 115_200,
  parameter int TRIG_CYC    = CLK_HZ / 100_000,
  parameter int CM_CYC      = CLK_HZ / 17_000,
  parameter int TIMEOUT_CYC = (CLK_HZ / 1000) * 60
) (
  input  logic clock,
  input  logic reset,
  input  logic ligar,
  input  logic echo1,
  input  logic echo2,
  input  logic echo3,
  output logic trigger1,
  output logic trigger2,
  output logic trigger3,
  output logic saida_serial,
  output logic pronto
);

  localparam int BW = $clog2(BAUD_DIV);
  localparam int TW = $clog2(TIMEOUT_CYC);
  localparam int SW = $clog2(CM_CYC);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_TRIG = 3'd1;
  localparam logic [2:0] S_MEAS = 3'd2;
  localparam logic [2:0] S_CONV = 3'd3;
  localparam logic [2:0] S_SEND = 3'd4;
  localparam logic [2:0] S_DONE = 3'd5;

`ifdef ROBERTO_CRLF_EN
  localparam logic [3:0] LAST = 4'd13;
`else
  localparam logic [3:0] LAST = 4'd11;
`endif

  logic [2:0]    state;
  logic [TW-1:0] tcnt;
  logic [2:0]    e_s1, e_s, e_p;
  logic [2:0]    armed, done;
  logic [2:0]    fall, done_n;
  logic [11:0]   bcd [3];
  logic [SW-1:0] sub [3];
  logic [3:0]    idx, sel_idx, bitc;
  logic [BW-1:0] baud;
  logic [9:0]    sh;
  logic [11:0]   v;
  logic [7:0]    tx_byte;

  function automatic logic [11:0] bcd_inc(input logic [11:0] x);
    logic [11:0] r;
    r = x;
    if (x != 12'h999) begin
      if (x[3:0] != 4'd9) begin
        r[3:0] = x[3:0] + 4'd1;
      end else begin
        r[3:0] = 4'd0;
        if (x[7:4] != 4'd9) begin
          r[7:4] = x[7:4] + 4'd1;
        end else begin
          r[7:4]  = 4'd0;
          r[11:8] = x[11:8] + 4'd1;
        end
      end
    end
    return r;
  endfunction

  assign trigger1     = (state == S_TRIG);
  assign trigger2     = (state == S_TRIG);
  assign trigger3     = (state == S_TRIG);
  assign pronto       = (state == S_DONE);
  assign saida_serial = (state == S_SEND) ? sh[0] : 1'b1;

  // A channel only arms after seeing its echo low, so stale highs are skipped
  assign fall   = armed & e_p & ~e_s;
  assign done_n = done | fall;

  assign sel_idx = (state == S_CONV) ? 4'd0 : idx + 4'd1;

  always_comb begin
    v = bcd[0];
    unique case (sel_idx[3:2])
      2'd0:    v = bcd[0];
      2'd1:    v = bcd[1];
      default: v = bcd[2];
    endcase
    tx_byte = 8'h23;
    unique case (sel_idx[1:0])
      2'd0:    tx_byte = {4'h3, v[11:8]};
      2'd1:    tx_byte = {4'h3, v[7:4]};
      2'd2:    tx_byte = {4'h3, v[3:0]};
      default: tx_byte = 8'h23;
    endcase
`ifdef ROBERTO_CRLF_EN
    if (sel_idx == 4'd12) tx_byte = 8'h0D;
    if (sel_idx == 4'd13) tx_byte = 8'h0A;
`endif
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= S_IDLE;
      tcnt  <= '0;
      e_s1  <= '0;
      e_s   <= '0;
      e_p   <= '0;
      armed <= '0;
      done  <= '0;
      for (int i = 0; i < 3; i++) begin
        bcd[i] <= '0;
        sub[i] <= '0;
      end
      idx  <= '0;
      bitc <= '0;
      baud <= '0;
      sh   <= '1;
    end else begin
      e_s1 <= {echo3, echo2, echo1};
      e_s  <= e_s1;
      e_p  <= e_s;
      unique case (state)
        S_IDLE: begin
          if (ligar) begin
            state <= S_TRIG;
            tcnt  <= '0;
            done  <= '0;
            for (int i = 0; i < 3; i++) begin
              bcd[i] <= '0;
              sub[i] <= SW'(CM_CYC / 2);
            end
          end
        end
        S_TRIG: begin
          tcnt  <= tcnt + 1'b1;
          armed <= ~e_s;
          if (tcnt == TW'(TRIG_CYC - 1)) state <= S_MEAS;
        end
        S_MEAS: begin
          tcnt  <= tcnt + 1'b1;
          armed <= armed | ~e_s;
          done  <= done_n;
          // Sub-counter starts at half a centimetre, giving round-to-nearest
          for (int i = 0; i < 3; i++) begin
            if (armed[i] && e_s[i] && !done[i]) begin
              if (sub[i] == SW'(CM_CYC - 1)) begin
                sub[i] <= '0;
                bcd[i] <= bcd_inc(bcd[i]);
              end else begin
                sub[i] <= sub[i] + 1'b1;
              end
            end
          end
          if ((&done_n) || (tcnt == TW'(TIMEOUT_CYC - 1))) begin
            state <= S_CONV;
            for (int i = 0; i < 3; i++) begin
              if (!done_n[i]) bcd[i] <= 12'h999;
            end
          end
        end
        S_CONV: begin
          sh    <= {1'b1, tx_byte, 1'b0};
          idx   <= '0;
          bitc  <= '0;
          baud  <= '0;
          state <= S_SEND;
        end
        S_SEND: begin
          if (baud == BW'(BAUD_DIV - 1)) begin
            baud <= '0;
            if (bitc == 4'd9) begin
              if (idx == LAST) begin
                state <= S_DONE;
              end else begin
                idx  <= idx + 1'b1;
                sh   <= {1'b1, tx_byte, 1'b0};
                bitc <= '0;
              end
            end else begin
              bitc <= bitc + 1'b1;
              sh   <= {1'b1, sh[9:1]};
            end
          end else begin
            baud <= baud + 1'b1;
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_roberto_sonar.sv
// Scoreboard bench for roberto_sonar with scaled-down timing parameters.
// Expected UART bytes are queued at stimulus time and popped as frames arrive.
module tb_roberto_sonar;

  localparam int BAUD = 8;
  localparam int TRIG = 20;
  localparam int CM   = 10;
  localparam int TMO  = 12000;
`ifdef ROBERTO_CRLF_EN
  localparam int NB = 14;
`else
  localparam int NB = 12;
`endif

  logic clock = 1'b0;
  logic reset = 1'b0;
  logic ligar = 1'b0;
  logic echo1 = 1'b0;
  logic echo2 = 1'b0;
  logic echo3 = 1'b0;
  logic trigger1, trigger2, trigger3;
  logic saida_serial, pronto;

  int checks = 0;
  int errors = 0;
  int pronto_cnt = 0;
  logic [7:0] exp_q [$];

  roberto_sonar #(
    .CLK_HZ(50_000_000),
    .BAUD_DIV(BAUD),
    .TRIG_CYC(TRIG),
    .CM_CYC(CM),
    .TIMEOUT_CYC(TMO)
  ) dut (
    .clock(clock),
    .reset(reset),
    .ligar(ligar),
    .echo1(echo1),
    .echo2(echo2),
    .echo3(echo3),
    .trigger1(trigger1),
    .trigger2(trigger2),
    .trigger3(trigger3),
    .saida_serial(saida_serial),
    .pronto(pronto)
  );

  always #10 clock = ~clock;

  always @(posedge clock) if (pronto === 1'b1) pronto_cnt++;

  function automatic int cm_of(input int w);
    int c;
    if (w < 0) return 999;
    c = (w + CM / 2) / CM;
    return (c > 999) ? 999 : c;
  endfunction

  task automatic push_ch(input int c);
    exp_q.push_back(8'(48 + c / 100));
    exp_q.push_back(8'(48 + (c / 10) % 10));
    exp_q.push_back(8'(48 + c % 10));
    exp_q.push_back(8'h23);
  endtask

  task automatic push_frame(input int w1, input int w2, input int w3);
    push_ch(cm_of(w1));
    push_ch(cm_of(w2));
    push_ch(cm_of(w3));
`ifdef ROBERTO_CRLF_EN
    exp_q.push_back(8'h0D);
    exp_q.push_back(8'h0A);
`endif
  endtask

  task automatic uart_rx(output logic [7:0] b, output int st);
    bit got;
    got = 0;
    b = '0;
    st = 1;
    for (int i = 0; i < 20000; i++) begin
      @(negedge clock);
      if (saida_serial === 1'b0) begin
        got = 1;
        break;
      end
    end
    if (got) begin
      st = 0;
      repeat (BAUD / 2) @(negedge clock);
      if (saida_serial !== 1'b0) st = 2;
      for (int k = 0; k < 8; k++) begin
        repeat (BAUD) @(negedge clock);
        b[k] = saida_serial;
      end
      repeat (BAUD) @(negedge clock);
      if (saida_serial !== 1'b1) st = 2;
    end
  endtask

  task automatic start_and_echo(input int w1, input int w2, input int w3,
                                input bit pre1, input bit hold);
    bit seen, tog;
    int hi;
    push_frame(w1, w2, w3);
    @(negedge clock);
    if (pre1) echo1 = 1'b1;
    ligar = 1'b1;
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      if (trigger1 === 1'b1) begin
        seen = 1;
        break;
      end
    end
    checks++;
    if (!seen) begin
      $display("FAIL trig_rise trigger1=%b required 1", trigger1);
      errors++;
    end
    hi = 0;
    tog = 1;
    while (trigger1 === 1'b1 && hi < 4 * TRIG) begin
      if ({trigger1, trigger2, trigger3} !== 3'b111) tog = 0;
      hi++;
      @(negedge clock);
      if (!hold) ligar = 1'b0;
    end
    checks++;
    if (!tog) begin
      $display("FAIL trig_together got mismatch required 111");
      errors++;
    end
    checks++;
    if (hi != TRIG) begin
      $display("FAIL trig_width got %0d required %0d", hi, TRIG);
      errors++;
    end
    fork
      begin
        if (pre1) begin
          repeat (5) @(negedge clock);
          echo1 = 1'b0;
        end
        repeat (10) @(negedge clock);
        if (w1 >= 0) begin
          echo1 = 1'b1;
          repeat (w1) @(negedge clock);
          echo1 = 1'b0;
        end
      end
      begin
        repeat (10) @(negedge clock);
        if (w2 >= 0) begin
          echo2 = 1'b1;
          repeat (w2) @(negedge clock);
          echo2 = 1'b0;
        end
      end
      begin
        repeat (10) @(negedge clock);
        if (w3 >= 0) begin
          echo3 = 1'b1;
          repeat (w3) @(negedge clock);
          echo3 = 1'b0;
        end
      end
    join
  endtask

  task automatic check_frame(input bit hold);
    logic [7:0] b;
    int st, p0, pr_at, tr_at;
    p0 = pronto_cnt;
    for (int n = 0; n < NB; n++) begin
      uart_rx(b, st);
      checks++;
      if (st != 0) begin
        $display("FAIL uart_frame byte %0d status %0d required 0", n, st);
        errors++;
        if (st == 1) break;
      end
      checks++;
      if (b !== exp_q[0]) begin
        $display("FAIL uart_byte %0d got %02h required %02h", n, b, exp_q[0]);
        errors++;
      end
      void'(exp_q.pop_front());
    end
    pr_at = -1;
    tr_at = -1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clock);
      if (pronto === 1'b1 && pr_at < 0) pr_at = i;
      if (trigger1 === 1'b1 && tr_at < 0) tr_at = i;
    end
    checks++;
    if (pronto_cnt - p0 != 1) begin
      $display("FAIL pronto_count got %0d required 1", pronto_cnt - p0);
      errors++;
    end
    checks++;
    if (hold && (pr_at < 0 || tr_at != pr_at + 2)) begin
      $display("FAIL restart got trig@%0d pronto@%0d required trig=pronto+2", tr_at, pr_at);
      errors++;
    end else if (!hold && tr_at >= 0) begin
      $display("FAIL no_restart got trig@%0d required none", tr_at);
      errors++;
    end
    exp_q.delete();
  endtask

  task automatic test_reset();
    bit bad;
    #5;
    checks++;
    if ({saida_serial, trigger1, trigger2, trigger3, pronto} !== 5'b10000) begin
      $display("FAIL reset_outputs got %b required 10000",
               {saida_serial, trigger1, trigger2, trigger3, pronto});
      errors++;
    end
    #15;
    reset = 1'b1;
    bad = 0;
    repeat (50) begin
      @(negedge clock);
      if ({saida_serial, trigger1, trigger2, trigger3} !== 4'b1000) bad = 1;
    end
    checks++;
    if (bad) begin
      $display("FAIL idle_outputs got activity required quiet");
      errors++;
    end
    checks++;
    if (pronto_cnt != 0) begin
      $display("FAIL idle_pronto got %0d required 0", pronto_cnt);
      errors++;
    end
  endtask

  task automatic test_main();
    start_and_echo(1000, 1000, 1000, 0, 0);
    check_frame(0);
  endtask

  task automatic test_rounding();
    start_and_echo(1003, 1003, 1003, 0, 0);
    check_frame(0);
    start_and_echo(740, 740, 740, 0, 0);
    check_frame(0);
    start_and_echo(748, 748, 748, 0, 0);
    check_frame(0);
    start_and_echo(744, 745, 1, 0, 0);
    check_frame(0);
  endtask

  task automatic test_saturate();
    start_and_echo(9984, 10000, 1, 0, 0);
    check_frame(0);
  endtask

  task automatic test_timeout();
    start_and_echo(740, 1000, -1, 0, 0);
    check_frame(0);
  endtask

  task automatic test_pre_echo();
    start_and_echo(740, 745, 1000, 1, 0);
    check_frame(0);
  endtask

  task automatic test_back_to_back();
    start_and_echo(1000, 1000, 1000, 0, 1);
    check_frame(1);
    @(negedge clock);
    ligar = 1'b0;
    push_frame(-1, -1, -1);
    check_frame(0);
  endtask

  task automatic test_reset_send();
    bit got, bad;
    start_and_echo(1000, 1000, 1000, 0, 0);
    got = 0;
    for (int i = 0; i < 20000; i++) begin
      @(negedge clock);
      if (saida_serial === 1'b0) begin
        got = 1;
        break;
      end
    end
    checks++;
    if (!got) begin
      $display("FAIL send_start got none required start bit");
      errors++;
    end
    repeat (2) @(negedge clock);
    reset = 1'b0;
    #1;
    checks++;
    if ({saida_serial, trigger1, trigger2, trigger3, pronto} !== 5'b10000) begin
      $display("FAIL abort_outputs got %b required 10000",
               {saida_serial, trigger1, trigger2, trigger3, pronto});
      errors++;
    end
    repeat (3) @(negedge clock);
    reset = 1'b1;
    exp_q.delete();
    bad = 0;
    repeat (100) begin
      @(negedge clock);
      if (saida_serial !== 1'b1 || pronto !== 1'b0) bad = 1;
    end
    checks++;
    if (bad) begin
      $display("FAIL abort_quiet got activity required idle line");
      errors++;
    end
    start_and_echo(744, 745, 1003, 0, 0);
    check_frame(0);
  endtask

  initial begin
    test_reset();
    test_main();
    test_rounding();
    test_saturate();
    test_timeout();
    test_pre_echo();
    test_back_to_back();
    test_reset_send();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
